// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI command sequencer with 8-bit register bank, ID and status reads.
// Optional build macro SPI_REG_CTRL_AUTOINC_EN enables burst pointer auto-increment.
module spi_reg_ctrl #(
   parameter int         NUM_REGS  = 16,
   parameter logic [7:0] ID_BYTE   = 8'hA5,
   parameter logic [7:0] IDLE_BYTE = 8'h0A
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cs_n,
   input  logic [7:0]              rx_byte,
   input  logic                    rx_valid,
   output logic [7:0]              tx_byte,
   output logic [8*NUM_REGS-1:0]   regs,
   output logic                    wr_strobe,
   output logic [6:0]              wr_addr
);

   localparam logic [6:0] REG_LIMIT   = 7'(NUM_REGS);
   localparam logic [6:0] STATUS_ADDR = 7'h7E;
   localparam logic [6:0] ID_ADDR     = 7'h7F;

   typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

   state_t     state;
   state_t     state_nxt;
   logic       cs_meta;
   logic       cs_s;
   logic [6:0] ptr;
   logic       err;
   logic [7:0] reg_q [NUM_REGS];

   logic       cmd_valid;
   logic       cmd_read;
   logic       wr_valid;
   logic       rd_valid;
   logic       wr_hit;
   logic [6:0] rd_addr;
   logic [7:0] rd_data;
   logic       rd_err_set;
   logic       rd_err_clr;

   function automatic logic [6:0] advance(input logic [6:0] a);
`ifdef SPI_REG_CTRL_AUTOINC_EN
      return a + 7'd1;
`else
      return a;
`endif
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_meta <= 1'b1;
         cs_s    <= 1'b1;
      end else begin
         cs_meta <= cs_n;
         cs_s    <= cs_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A byte arriving with the frame end is still handled by the current state.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!cs_s) state_nxt = CMD;
         CMD:     if (rx_valid) state_nxt = rx_byte[7] ? READ : WRITE;
         WRITE:   state_nxt = WRITE;
         READ:    state_nxt = READ;
         default: state_nxt = IDLE;
      endcase
      if (cs_s) state_nxt = IDLE;
   end

   always_comb begin
      cmd_valid = (state == CMD) && rx_valid;
      cmd_read  = cmd_valid && rx_byte[7];
      wr_valid  = (state == WRITE) && rx_valid;
      rd_valid  = (state == READ) && rx_valid;
      wr_hit    = (ptr < REG_LIMIT);
      rd_addr   = (state == CMD) ? rx_byte[6:0] : ptr;
   end

   always_comb begin
      rd_data    = 8'h00;
      rd_err_set = 1'b0;
      rd_err_clr = 1'b0;
      if (rd_addr < REG_LIMIT) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == 7'(k)) rd_data = reg_q[k];
         end
      end else if (rd_addr == STATUS_ADDR) begin
         rd_data    = {7'b0, err};
         rd_err_clr = 1'b1;
      end else if (rd_addr == ID_ADDR) begin
         rd_data = ID_BYTE;
      end else begin
         rd_err_set = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_REGS; k++) reg_q[k] <= 8'h00;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_valid && wr_hit && (ptr == 7'(k))) reg_q[k] <= rx_byte;
         end
      end
   end

   // Read commands prefetch: the pointer already points past the byte just loaded into tx_byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= 7'd0;
         err       <= 1'b0;
         tx_byte   <= IDLE_BYTE;
         wr_strobe <= 1'b0;
         wr_addr   <= 7'd0;
      end else begin
         wr_strobe <= 1'b0;

         if (cmd_valid) begin
            ptr <= rx_byte[7] ? advance(rx_byte[6:0]) : rx_byte[6:0];
         end else if (wr_valid || rd_valid) begin
            ptr <= advance(ptr);
         end

         if (wr_valid) begin
            if (wr_hit) begin
               wr_strobe <= 1'b1;
               wr_addr   <= ptr;
            end else begin
               err <= 1'b1;
            end
         end

         if (cmd_read || rd_valid) begin
            if (rd_err_clr)      err <= 1'b0;
            else if (rd_err_set) err <= 1'b1;
         end

         if (state_nxt == IDLE)          tx_byte <= IDLE_BYTE;
         else if (cmd_read || rd_valid)  tx_byte <= rd_data;
         else if (cmd_valid)             tx_byte <= IDLE_BYTE;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs[8*g +: 8] = reg_q[g];
   end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - directed self-checking bench for spi_reg_ctrl (both SPI_REG_CTRL_AUTOINC_EN builds).
module tb_spi_reg_ctrl;

`ifdef SPI_REG_CTRL_AUTOINC_EN
   localparam bit AI = 1'b1;
`else
   localparam bit AI = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cs_n;
   logic [7:0]   rx_byte;
   logic         rx_valid;
   logic [7:0]   tx_byte;
   logic [127:0] regs;
   logic         wr_strobe;
   logic [6:0]   wr_addr;

   int errors = 0;
   int checks = 0;
   int stb_count = 0;

   spi_reg_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .tx_byte(tx_byte), .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_strobe === 1'b1) stb_count++;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] reg_of(input int k);
      return regs[8*k +: 8];
   endfunction

   task automatic start_frame();
      @(negedge clk);
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic end_frame();
      @(negedge clk);
      cs_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic stb, output logic [6:0] addr,
                            output logic [7:0] tx);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      stb  = wr_strobe;
      addr = wr_addr;
      tx   = tx_byte;
      repeat (3) @(negedge clk);
   endtask

   logic         s;
   logic [6:0]   a;
   logic [7:0]   t;
   logic [127:0] snap;
   int           base;
   logic [7:0]   wdat [3];
   logic [7:0]   rexp [3];

   initial begin
      rst_n = 1'b0; cs_n = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx_byte, 8'h0A);
      check("rst_stb", wr_strobe, 1'b0);
      check("rst_addr", wr_addr, 7'd0);
      check("rst_regs", regs, 128'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // write burst {02,11,22,33}
      wdat = '{8'h11, 8'h22, 8'h33};
      start_frame();
      send_byte(8'h02, s, a, t);
      check("wcmd_stb", s, 1'b0);
      check("wcmd_tx", t, 8'h0A);
      for (int i = 0; i < 3; i++) begin
         send_byte(wdat[i], s, a, t);
         check($sformatf("wb_stb%0d", i), s, 1'b1);
         check($sformatf("wb_addr%0d", i), a, AI ? 7'(2 + i) : 7'd2);
         check($sformatf("wb_tx%0d", i), t, 8'h0A);
      end
      end_frame();
      check("reg2", reg_of(2), AI ? 8'h11 : 8'h33);
      check("reg3", reg_of(3), AI ? 8'h22 : 8'h00);
      check("reg4", reg_of(4), AI ? 8'h33 : 8'h00);

      // read burst {82,xx,xx,xx}
      rexp = AI ? '{8'h22, 8'h33, 8'h00} : '{8'h33, 8'h33, 8'h33};
      start_frame();
      send_byte(8'h82, s, a, t);
      check("rb_cmd_tx", t, AI ? 8'h11 : 8'h33);
      for (int i = 0; i < 3; i++) begin
         send_byte(8'hC3, s, a, t);
         check($sformatf("rb_tx%0d", i), t, rexp[i]);
         check($sformatf("rb_stb%0d", i), s, 1'b0);
      end
      end_frame();
      check("rb_end_tx", tx_byte, 8'h0A);

      // load reg0/reg1, then ID read wrapping to 0x00
      start_frame();
      send_byte(8'h00, s, a, t);
      send_byte(8'h5A, s, a, t);
      send_byte(8'hC3, s, a, t);
      end_frame();
      check("reg0", reg_of(0), AI ? 8'h5A : 8'hC3);
      start_frame();
      send_byte(8'hFF, s, a, t);
      check("id_tx", t, 8'hA5);
      send_byte(8'h00, s, a, t);
      check("wrap_tx0", t, AI ? 8'h5A : 8'hA5);
      send_byte(8'h00, s, a, t);
      check("wrap_tx1", t, AI ? 8'hC3 : 8'hA5);
      end_frame();

      // last register and one past it
      start_frame();
      send_byte(8'h0F, s, a, t);
      send_byte(8'hEE, s, a, t);
      check("r15_stb", s, 1'b1);
      check("r15_addr", a, 7'd15);
      send_byte(8'h44, s, a, t);
      check("r16_stb", s, AI ? 1'b0 : 1'b1);
      end_frame();
      check("reg15", reg_of(15), AI ? 8'hEE : 8'h44);
      start_frame();
      send_byte(8'hFE, s, a, t);
      end_frame();
      check("stat_edge", t, AI ? 8'h01 : 8'h00);

      // out-of-range write, status set then cleared
      snap = regs;
      base = stb_count;
      start_frame();
      send_byte(8'h20, s, a, t);
      send_byte(8'h55, s, a, t);
      end_frame();
      check("oor_stbs", 32'(stb_count - base), 32'd0);
      check("oor_regs", regs, snap);
      start_frame();
      send_byte(8'hFE, s, a, t);
      end_frame();
      check("stat_set", t, 8'h01);
      start_frame();
      send_byte(8'hFE, s, a, t);
      end_frame();
      check("stat_clr", t, 8'h00);

      // unmapped read returns 0 and flags error
      start_frame();
      send_byte(8'h90, s, a, t);
      end_frame();
      check("unmapped_tx", t, 8'h00);
      start_frame();
      send_byte(8'hFE, s, a, t);
      end_frame();
      check("stat_rd_err", t, 8'h01);

      // zero-data write frame: no strobe, no error
      base = stb_count;
      start_frame();
      send_byte(8'h06, s, a, t);
      end_frame();
      check("zero_stbs", 32'(stb_count - base), 32'd0);
      start_frame();
      send_byte(8'hFE, s, a, t);
      end_frame();
      check("zero_stat", t, 8'h00);

      // reset mid-frame
      start_frame();
      send_byte(8'h05, s, a, t);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_regs", regs, 128'h0);
      check("mrst_tx", tx_byte, 8'h0A);
      cs_n = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      start_frame();
      send_byte(8'h05, s, a, t);
      send_byte(8'h77, s, a, t);
      check("post_stb", s, 1'b1);
      check("post_addr", a, 7'd5);
      end_frame();
      check("post_reg5", reg_of(5), 8'h77);
      check("post_reg4", reg_of(4), 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
